// File: rtl/maze_move_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maze_move_controller_if : button/maze inputs and player-position outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface maze_move_controller_if #(
  parameter int COLS = 18,
  parameter int ROWS = 11
);
  localparam int CELLS = COLS * ROWS;

  logic             tick;
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_ctrl;
  logic             pause;
  logic [CELLS-1:0] maze_state;

  logic [7:0]       pos;
  logic [3:0]       row;
  logic [4:0]       col;
  logic [9:0]       move_count;
  logic             at_goal;
  logic             moved;
  logic             bump;

  modport master (
    output tick, btn_up, btn_down, btn_left, btn_right, btn_ctrl, pause, maze_state,
    input  pos, row, col, move_count, at_goal, moved, bump
  );

  modport slave (
    input  tick, btn_up, btn_down, btn_left, btn_right, btn_ctrl, pause, maze_state,
    output pos, row, col, move_count, at_goal, moved, bump
  );
endinterface
`default_nettype wire

// File: rtl/maze_move_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maze_move_controller : buttons -> player cell with wall checks, auto-repeat
// Rev 1.0
// ---------------------------------------------------------------------------
module maze_move_controller #(
  parameter int COLS         = 18,
  parameter int ROWS         = 11,
  parameter int START_ROW    = 1,
  parameter int START_COL    = 0,
  parameter int GOAL_ROW     = 9,
  parameter int GOAL_COL     = 17,
  parameter int REPEAT_TICKS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  maze_move_controller_if.slave mv
);

  localparam int HW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [7:0]    START_POS = 8'(START_ROW * COLS + START_COL);
  localparam logic [3:0]    START_R   = 4'(START_ROW);
  localparam logic [4:0]    START_C   = 5'(START_COL);
  localparam logic [3:0]    GOAL_R    = 4'(GOAL_ROW);
  localparam logic [4:0]    GOAL_C    = 5'(GOAL_COL);
  localparam logic [3:0]    LAST_ROW  = 4'(ROWS - 1);
  localparam logic [4:0]    LAST_COL  = 5'(COLS - 1);
  localparam logic [7:0]    COLS_W    = 8'(COLS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_TICKS - 1);
  localparam logic [9:0]    COUNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

  state_t        state, state_n;
  dir_t          dir, dir_n, att_dir;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]    row, row_n, tgt_row;
  logic [4:0]    col, col_n, tgt_col;
  logic [7:0]    pos, pos_n, tgt_pos;
  logic [9:0]    move_count, count_n;
  logic          at_goal, goal_n;
  logic          moved, moved_n;
  logic          bump, bump_n;

  logic [3:0]    dir_btn, dir_prev, dir_press, higher_mask, higher_press;
  logic          ctrl_prev, ctrl_press;
  logic          attempt, edge_blocked, blocked;

  // Bit index of dir_btn matches dir_t so the latched button is dir_btn[dir].
  assign dir_btn      = {mv.btn_right, mv.btn_left, mv.btn_down, mv.btn_up};
  assign dir_press    = dir_btn & ~dir_prev;
  assign ctrl_press   = mv.btn_ctrl & ~ctrl_prev;
  assign higher_press = dir_press & higher_mask;

  function automatic dir_t first_dir(input logic [3:0] v);
    if (v[0])      return DIR_UP;
    else if (v[1]) return DIR_DOWN;
    else if (v[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

  always_comb begin
    unique case (dir)
      DIR_UP:    higher_mask = 4'b0000;
      DIR_DOWN:  higher_mask = 4'b0001;
      DIR_LEFT:  higher_mask = 4'b0011;
      DIR_RIGHT: higher_mask = 4'b0111;
      default:   higher_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_n      = state;
    dir_n        = dir;
    hold_n       = hold_cnt;
    row_n        = row;
    col_n        = col;
    pos_n        = pos;
    count_n      = move_count;
    goal_n       = at_goal;
    moved_n      = 1'b0;
    bump_n       = 1'b0;
    attempt      = 1'b0;
    att_dir      = dir;
    edge_blocked = 1'b0;
    blocked      = 1'b0;
    tgt_row      = row;
    tgt_col      = col;
    tgt_pos      = pos;

    if (ctrl_press) begin
      state_n = IDLE;
      hold_n  = '0;
      row_n   = START_R;
      col_n   = START_C;
      pos_n   = START_POS;
      count_n = '0;
      goal_n  = 1'b0;
    end else if (!mv.pause) begin
      unique case (state)
        IDLE: begin
          if (|dir_press) begin
            att_dir = first_dir(dir_press);
            attempt = 1'b1;
            dir_n   = att_dir;
            hold_n  = '0;
            state_n = HELD;
          end
        end
        HELD: begin
          if (!dir_btn[dir]) begin
            state_n = IDLE;
          end else if (|higher_press) begin
            att_dir = first_dir(higher_press);
            attempt = 1'b1;
            dir_n   = att_dir;
            hold_n  = '0;
          end else if (mv.tick) begin
            if (hold_cnt == HOLD_LAST) begin
              attempt = 1'b1;
              hold_n  = '0;
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_n = IDLE;
      endcase
    end

    unique case (att_dir)
      DIR_UP: begin
        edge_blocked = (row == 4'd0);
        tgt_row      = row - 4'd1;
        tgt_pos      = pos - COLS_W;
      end
      DIR_DOWN: begin
        edge_blocked = (row == LAST_ROW);
        tgt_row      = row + 4'd1;
        tgt_pos      = pos + COLS_W;
      end
      DIR_LEFT: begin
        edge_blocked = (col == 5'd0);
        tgt_col      = col - 5'd1;
        tgt_pos      = pos - 8'd1;
      end
      DIR_RIGHT: begin
        edge_blocked = (col == LAST_COL);
        tgt_col      = col + 5'd1;
        tgt_pos      = pos + 8'd1;
      end
      default: edge_blocked = 1'b1;
    endcase

    // The map is only indexed once the target is known to be on the board.
    blocked = edge_blocked ? 1'b1 : ~mv.maze_state[tgt_pos];

    if (attempt) begin
      if (blocked) begin
        bump_n = 1'b1;
      end else begin
        row_n   = tgt_row;
        col_n   = tgt_col;
        pos_n   = tgt_pos;
        moved_n = 1'b1;
        if (move_count != COUNT_MAX) count_n = move_count + 10'd1;
        if (tgt_row == GOAL_R && tgt_col == GOAL_C) begin
          state_n = DONE;
          goal_n  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      dir        <= DIR_UP;
      hold_cnt   <= '0;
      row        <= START_R;
      col        <= START_C;
      pos        <= START_POS;
      move_count <= '0;
      at_goal    <= 1'b0;
      moved      <= 1'b0;
      bump       <= 1'b0;
      dir_prev   <= '1;
      ctrl_prev  <= 1'b1;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      hold_cnt   <= hold_n;
      row        <= row_n;
      col        <= col_n;
      pos        <= pos_n;
      move_count <= count_n;
      at_goal    <= goal_n;
      moved      <= moved_n;
      bump       <= bump_n;
      dir_prev   <= dir_btn;
      ctrl_prev  <= mv.btn_ctrl;
    end
  end

  assign mv.pos        = pos;
  assign mv.row        = row;
  assign mv.col        = col;
  assign mv.move_count = move_count;
  assign mv.at_goal    = at_goal;
  assign mv.moved      = moved;
  assign mv.bump       = bump;

endmodule
`default_nettype wire

// File: tb/tb_maze_move_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_maze_move_controller : directed stimulus, cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_maze_move_controller;
  localparam int NC  = 18;
  localparam int NR  = 11;
  localparam int REP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_move_controller_if #(.COLS(NC), .ROWS(NR)) mv();

  maze_move_controller #(
    .COLS(NC), .ROWS(NR), .START_ROW(1), .START_COL(0),
    .GOAL_ROW(9), .GOAL_COL(17), .REPEAT_TICKS(REP)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .mv (mv)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference: player as (row, col) on a grid; held = 0 none, 1..4 up/down/left/right.
  int m_row, m_col, m_cnt, m_held, m_hold;
  bit m_goal, m_moved, m_bump;
  logic [4:0] m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pos();
    return m_row * NC + m_col;
  endfunction

  function automatic void m_try(input int d);
    int nr, nc;
    nr = m_row + ((d == 1) ? -1 : (d == 2) ? 1 : 0);
    nc = m_col + ((d == 3) ? -1 : (d == 4) ? 1 : 0);
    if (nr < 0 || nr >= NR || nc < 0 || nc >= NC || mv.maze_state[nr * NC + nc] == 1'b0) begin
      m_bump = 1'b1;
    end else begin
      m_row   = nr;
      m_col   = nc;
      m_moved = 1'b1;
      if (m_cnt < 1023) m_cnt++;
      if (nr == 9 && nc == 17) m_goal = 1'b1;
    end
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] b, p;
    bit found;
    b = {mv.btn_right, mv.btn_left, mv.btn_down, mv.btn_up, mv.btn_ctrl};
    m_moved = 1'b0;
    m_bump  = 1'b0;
    if (rst) begin
      m_row = 1; m_col = 0; m_cnt = 0; m_goal = 1'b0;
      m_held = 0; m_hold = 0; m_prev = '1;
    end else begin
      p = b & ~m_prev;
      m_prev = b;
      if (p[0]) begin
        m_row = 1; m_col = 0; m_cnt = 0; m_goal = 1'b0; m_held = 0; m_hold = 0;
      end else if (!mv.pause && !m_goal) begin
        if (m_held == 0) begin
          found = 1'b0;
          for (int d = 1; d <= 4; d++) begin
            if (p[d] && !found) begin
              found = 1'b1; m_held = d; m_hold = 0; m_try(d);
            end
          end
        end else if (!b[m_held]) begin
          m_held = 0;
        end else begin
          found = 1'b0;
          for (int d = 1; d <= 4; d++) begin
            if (d < m_held && p[d] && !found) begin
              found = 1'b1; m_held = d; m_hold = 0; m_try(d);
            end
          end
          if (!found && mv.tick) begin
            m_hold++;
            if (m_hold == REP) begin
              m_hold = 0;
              m_try(m_held);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("pos",        32'(mv.pos),        32'(m_pos()));
      check("row",        32'(mv.row),        32'(m_row));
      check("col",        32'(mv.col),        32'(m_col));
      check("move_count", 32'(mv.move_count), 32'(m_cnt));
      check("at_goal",    32'(mv.at_goal),    32'(m_goal));
      check("moved",      32'(mv.moved),      32'(m_moved));
      check("bump",       32'(mv.bump),       32'(m_bump));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0: mv.btn_ctrl  = v;
      1: mv.btn_up    = v;
      2: mv.btn_down  = v;
      3: mv.btn_left  = v;
      default: mv.btn_right = v;
    endcase
  endtask

  task automatic tap(input int d);
    set_btn(d, 1'b1);
    step();
    set_btn(d, 1'b0);
    step();
  endtask

  initial begin
    mv.tick = 1'b0; mv.pause = 1'b0;
    mv.btn_up = 1'b0; mv.btn_down = 1'b0; mv.btn_left = 1'b0;
    mv.btn_right = 1'b1; mv.btn_ctrl = 1'b0;
    mv.maze_state = '0;
    for (int c = 0; c < NC; c++) mv.maze_state[1 * NC + c] = 1'b1;
    for (int r = 1; r <= 9; r++) mv.maze_state[r * NC + 17] = 1'b1;
    mv.maze_state[2 * NC + 0] = 1'b1;

    // Reset with right already held: no move until released and pressed again
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step(3);
    check("reset pos", 32'(mv.pos), 32'd18);
    check("reset row", 32'(mv.row), 32'd1);
    check("reset col", 32'(mv.col), 32'd0);
    check("reset count", 32'(mv.move_count), 32'd0);
    mv.btn_right = 1'b0;
    step();
    tap(4);
    check("first right", 32'(mv.pos), 32'd19);
    tap(4);
    check("second right", 32'(mv.pos), 32'd20);
    check("count two", 32'(mv.move_count), 32'd2);

    // Edge and wall bumps
    tap(0);
    mv.btn_left = 1'b1;
    step();
    check("left edge bump", 32'(mv.bump), 32'd1);
    check("left edge pos", 32'(mv.pos), 32'd18);
    mv.btn_left = 1'b0;
    step();
    check("bump one cycle", 32'(mv.bump), 32'd0);
    tap(4);
    mv.btn_up = 1'b1;
    step();
    check("up wall bump", 32'(mv.bump), 32'd1);
    check("up wall count", 32'(mv.move_count), 32'd1);
    mv.btn_up = 1'b0;
    step();

    // Auto-repeat: moves at press, after tick 3 and after tick 6
    tap(0);
    mv.btn_right = 1'b1;
    step();
    check("hold press", 32'(mv.pos), 32'd19);
    for (int t = 1; t <= 7; t++) begin
      mv.tick = 1'b1;
      step();
      mv.tick = 1'b0;
      step();
      if (t == 2) check("hold tick2", 32'(mv.pos), 32'd19);
      if (t == 3) check("hold tick3", 32'(mv.pos), 32'd20);
      if (t == 6) check("hold tick6", 32'(mv.pos), 32'd21);
      if (t == 7) check("hold tick7", 32'(mv.pos), 32'd21);
    end
    mv.btn_up = 1'b1;
    step();
    check("relatch up bump", 32'(mv.bump), 32'd1);
    mv.btn_up = 1'b0;
    mv.btn_right = 1'b0;
    step(2);

    // Press during pause is consumed
    tap(0);
    mv.pause = 1'b1;
    tap(2);
    mv.pause = 1'b0;
    step(2);
    check("pause no move", 32'(mv.pos), 32'd18);
    tap(2);
    check("down after pause", 32'(mv.pos), 32'd36);
    tap(0);
    mv.btn_up = 1'b1;
    mv.btn_down = 1'b1;
    step();
    check("up wins bump", 32'(mv.bump), 32'd1);
    check("up wins pos", 32'(mv.pos), 32'd18);
    mv.btn_up = 1'b0;
    mv.btn_down = 1'b0;
    step();

    // Counter saturation
    for (int i = 0; i < 520; i++) begin
      tap(4);
      tap(3);
    end
    check("count saturates", 32'(mv.move_count), 32'd1023);
    tap(0);
    check("ctrl clears count", 32'(mv.move_count), 32'd0);

    // Path to the goal, then frozen until ctrl
    for (int i = 0; i < 17; i++) tap(4);
    for (int i = 0; i < 8; i++) tap(2);
    check("goal pos", 32'(mv.pos), 32'd179);
    check("goal flag", 32'(mv.at_goal), 32'd1);
    check("goal count", 32'(mv.move_count), 32'd25);
    tap(3);
    tap(1);
    tap(2);
    check("done frozen pos", 32'(mv.pos), 32'd179);
    check("done frozen count", 32'(mv.move_count), 32'd25);
    tap(0);
    check("restart pos", 32'(mv.pos), 32'd18);
    check("restart count", 32'(mv.move_count), 32'd0);
    check("restart goal", 32'(mv.at_goal), 32'd0);

    // Reset while holding a direction
    mv.btn_right = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(2);
    check("rst mid-hold pos", 32'(mv.pos), 32'd18);
    mv.btn_right = 1'b0;
    step(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/maze_move_controller.md
Name: maze_move_controller

Overview:
- Upstream stage of the maze renderer and red-square overlay. Turns debounced push-button levels into a player cell position inside the 198-bit maze map.
- Performs wall and edge checks, press-and-hold auto-repeat, a move counter, goal detection and a pause freeze.
- Its pos output is the position counter consumed by the maze drawing and red-square blocks.

Parameters:
- COLS, 18, maze width in cells
- ROWS, 11, maze height in cells (COLS*ROWS = 198)
- START_ROW, 1, reset/restart row
- START_COL, 0, reset/restart column
- GOAL_ROW, 9, goal row
- GOAL_COL, 17, goal column
- REPEAT_TICKS, 3, tick pulses a button must stay held before each auto-repeat move

Ports:
- CLK  in  1  system clock; one clock, all logic on its rising edge
- RST  in  1  synchronous reset, active-high
- tick  in  1  one-CLK-wide repeat-rate strobe (10 Hz class)
- btn_up, btn_down, btn_left, btn_right, btn_ctrl  in  1 each  debounced button levels
- pause  in  1  freeze movement while high
- maze_state  in  198  bit (row*COLS+col) = 1 means open cell, 0 means wall
- pos  out  8  row*COLS+col of the player
- row  out  4  player row
- col  out  5  player column
- move_count  out  10  successful moves, saturates at 1023
- at_goal  out  1  player is on the goal cell
- moved  out  1  one-CLK pulse on each successful move
- bump  out  1  one-CLK pulse on each blocked move attempt

Behaviour:
- Reset (RST high at an edge):
  - row=START_ROW, col=START_COL, pos=START_ROW*COLS+START_COL, move_count=0, at_goal=0, moved=0, bump=0, hold_cnt=0, state=IDLE.
  - The previous-button register is set to all ones, so buttons already held at reset do not generate a press.
- Position arithmetic:
  - Keep row and col in registers; pos is registered alongside them. No divider.
  - up: row-1, pos-COLS. down: row+1, pos+COLS. left: col-1, pos-1. right: col+1, pos+1.
- Edge detection: a press is the button high now while its previous-cycle sample is low. The previous-button register updates every cycle, including during pause and DONE.
- Request priority, one per cycle: ctrl > up > down > left > right.
- ctrl press in any state: restore the start cell, clear move_count and at_goal, go to IDLE. The move counter resets to 0.
- Move attempt:
  - Blocked when the target is out of bounds (row 0 going up, row ROWS-1 going down, col 0 going left, col COLS-1 going right) or the target bit in maze_state is 0.
  - Blocked: bump=1 for one cycle; position and move_count unchanged.
  - Allowed: position updates at the same edge that samples the request, so outputs are visible on the next cycle (latency 1 CLK). moved=1 for one cycle. move_count increments, saturating at 1023.
- State machine:
  - IDLE: a direction press makes a move attempt, latches that direction, sets hold_cnt=0 and goes to HELD.
  - HELD:
    - If the latched button goes low, go to IDLE.
    - A press of a higher-priority direction re-latches to that direction, attempts it, and clears hold_cnt.
    - On tick: if hold_cnt==REPEAT_TICKS-1, attempt the latched direction and set hold_cnt=0; otherwise hold_cnt+1.
  - DONE: entered on the same edge that moves the player onto the goal; at_goal=1. All direction requests are ignored and give no bump. Only ctrl or RST leave DONE.
- pause high:
  - No move attempts and no bump.
  - hold_cnt is frozen and the state is held. ctrl is still honoured.
  - Presses that occur during pause are consumed and do not fire when pause is released.
- maze_state changing mid-game: the check always uses the current value. If the player already sits on a cell that is now closed, no correction is made.
- tick and a new press in the same cycle: the press wins, and hold_cnt clears.
- RST mid-hold or in DONE: full reset as above.

Test Plan:
- Reset with btn_right held and the cell at pos 19 open -> after reset pos=18, row=1, col=0, and no move until btn_right is released and pressed again.
- Open row 1, cols 0-3; pulse btn_right twice -> pos 19 then 20, moved pulses twice, move_count=2.
- From col 0, press btn_left -> bump=1 for 1 cycle, pos stays 18; with pos-COLS a wall, btn_up -> bump, move_count unchanged.
- Hold btn_right with REPEAT_TICKS=3 and 7 tick pulses along an open row -> moves at the press, after tick 3 and after tick 6: pos 18→19→20→21.
- Path to (9,17): the final move gives pos=179 and at_goal=1; further direction presses produce no change and no bump; btn_ctrl -> pos=18, move_count=0, at_goal=0.
- pause=1, press btn_down, release, then pause=0 -> no move occurs; btn_up and btn_down pressed in the same cycle -> only the up attempt is made.
